sdpram_arbiter: RTL
===================

# sdpram_arbiter

Round-robin arbiter that shares one Simple Dual Port RAM, configured for one-cycle read latency, between NUM_REQ independent requesters. Write and read ports are arbitrated separately, so one write and one read can be granted per cycle. Each requester uses a valid/ready request handshake. Read data returns to the originating requester through a tagged response pipeline. The block sits between client engines and a single SDPRAM instance; it owns every SDPRAM input.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 64, RAM row width [bit], multiple of 8
- DEPTH, 512, RAM rows; AW = $clog2(DEPTH)

- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- WREQ_VALID  in  NUM_REQ  per-requester write request
- WREQ_READY  out  NUM_REQ  one-hot write grant; accept when VALID&READY
- WREQ_ADDR  in  NUM_REQ*AW  packed write addresses, requester i at [i*AW +: AW]
- WREQ_DATA  in  NUM_REQ*WIDTH  packed write data
- WREQ_STRB  in  NUM_REQ*WIDTH/8  packed byte strobes
- RREQ_VALID  in  NUM_REQ  per-requester read request
- RREQ_READY  out  NUM_REQ  one-hot read grant
- RREQ_ADDR  in  NUM_REQ*AW  packed read addresses
- RRSP_VALID  out  NUM_REQ  one-hot read response strobe; there is no backpressure
- RRSP_DATA  out  WIDTH  read data, shared by all requesters
- RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_WSTRB  out  1/AW/WIDTH/WIDTH/8  to the SDPRAM write port
- RAM_REN, RAM_RADDR  out  1/AW  to the SDPRAM read port
- RAM_RVALID, RAM_RDATA  in  1/WIDTH  from the SDPRAM; data arrives one cycle after RAM_REN

## Operation
- **Write grant**
  - Combinational from WREQ_VALID and the write pointer wptr.
  - The first valid requester at or after wptr, wrapping modulo NUM_REQ, wins.
  - WREQ_READY is nonzero only when at least one VALID is high.
- **Write accept**
  - On accept of requester g, the same cycle drives RAM_WEN=1 and the WADDR/WDATA/WSTRB slices of g.
  - wptr <= (g+1) mod NUM_REQ.
  - wptr is unchanged when nothing is accepted.
- **Read path**
  - Uses an independent pointer rptr and identical grant rules.
  - Accept drives RAM_REN=1 and RAM_RADDR from the winning slice.
  - Tag {valid, idx} enters a two-stage pipeline: t1 aligns with RAM_RVALID, t2 is the response register.
- **Response**
  - When RAM_RVALID=1 and t1.valid: RRSP_DATA <= RAM_RDATA and RRSP_VALID <= onehot(t1.idx), otherwise RRSP_VALID <= 0.
  - RRSP_DATA holds its last value when no response is issued.
  - RAM_RVALID=1 with t1.valid=0 is a protocol error: the data is dropped (see Configuration).
- **Same-address hazard**
  - A write and a read to the same address accepted in the same cycle return the old data.
  - A read accepted the cycle after a write returns the new data.
- **Requester rules**
  - A requester may drop VALID without being granted. No request is lost or duplicated.
- **Reset**
  - Async assert: wptr=rptr=0, all tags invalid, RRSP_VALID=0, RRSP_DATA=0.
  - While RST=1: WREQ_READY=RREQ_READY=0, RAM_WEN=RAM_REN=0.
  - Reads in flight when reset asserts produce no response.

## Timing
- Request to grant: 0 cycles; READY depends combinationally on VALID.
- Read accept (cycle N) -> RAM_RVALID (N+1) -> RRSP_VALID (N+2). Latency is 2 cycles and fixed.
- Throughput: one write plus one read per cycle sustained.
- Fairness: under continuous all-VALID load, each requester is granted once per NUM_REQ cycles.
- Back-to-back reads from different requesters produce back-to-back responses in acceptance order.

## Configuration
- SDPRAM_ARBITER_RR_EN
  - Defined: round-robin as above.
  - Undefined: fixed priority, lowest index wins. wptr and rptr are not implemented and tie to 0.
- An orphan RAM_RVALID is dropped silently in both configurations.

## Structure
- Package sdpram_arbiter_pkg:
  - rsp_tag_t struct {valid, idx[$clog2(NUM_REQ)-1:0]}
  - onehot/index helper functions
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs VALID and ACCEPT; output GRANT one-hot.
  - Contains the pointer and the macro-selected policy.
  - Instantiated twice, once for the write port and once for the read port.

## Test plan
- **Single read after write.** Requester 2 writes 0xDEADBEEF_00000001 to address 5 with WSTRB=0xFF. Requester 0 then reads address 5. Required: RRSP_VALID=4'b0001 exactly 2 cycles after the read accept, with matching RRSP_DATA.
- **Byte strobes.** Write 0x11..11 to address 3, then write 0xFF..FF to address 3 with WSTRB=0x0F. Required: a read of address 3 returns 0x11111111_FFFFFFFF.
- **Round-robin fairness.** All four RREQ_VALID held high for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3, and responses tagged in the same order. With the macro undefined, requester 0 wins every cycle.
- **Simultaneous write and read, same address.** Address 7 holds 0xA. In one cycle, write 0xB to address 7 and read address 7. Required: the read returns 0xA. A read on the next cycle returns 0xB.
- **Reset mid-operation.** Assert RST 1 cycle after a read accept. Required: no RRSP_VALID appears. After release, pointers are at 0 and the first grant goes to requester 0.
- **Drop VALID without grant.** Requester 1 raises RREQ_VALID while requester 0 is granted, then drops it the next cycle without a grant. Required: no RAM_REN issued for requester 1 and no response to it.

Source files
------------

// File: rtl/sdpram_arbiter_pkg.sv
// Shared types and helpers for the SDPRAM arbiter.
// Build option: SDPRAM_ARBITER_RR_EN selects round-robin; otherwise fixed priority.
package sdpram_arbiter_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    // Read response tag carried alongside the RAM read latency
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rsp_tag_t;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sdpram_arbiter_rr.sv
// Single-port request arbiter with its own rotating pointer.
// Build option: SDPRAM_ARBITER_RR_EN enables round-robin; undefined gives
// fixed priority (lowest index wins) with the pointer tied to zero.
import sdpram_arbiter_pkg::*;

module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] VALID,
    input  logic               ACCEPT,
    output logic [NUM_REQ-1:0] GRANT
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0] w_ptr;

`ifdef SDPRAM_ARBITER_RR_EN
    logic [PW-1:0] r_ptr;

    // Move the pointer just past the accepted requester so it ranks last next time
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= '0;
        end else if (ACCEPT) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (GRANT[i]) r_ptr <= (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    logic w_unused;

    assign w_ptr    = '0;
    assign w_unused = ^{CLK, RST, ACCEPT};
`endif

    // Grant the first VALID at or after the pointer, wrapping around
    always_comb begin
        int unsigned v_idx;
        logic        v_found;
        GRANT   = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = (32'(w_ptr) + k) % NUM_REQ;
            if (!v_found && VALID[v_idx]) begin
                v_found      = 1'b1;
                GRANT[v_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdpram_arbiter.sv
// Shares one SDPRAM (1-cycle read latency) between NUM_REQ requesters with
// independent write and read arbitration and a tagged read-response path.
// Build option: SDPRAM_ARBITER_RR_EN (round-robin vs fixed priority).
import sdpram_arbiter_pkg::*;

module sdpram_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned WIDTH   = 64,
    parameter  int unsigned DEPTH   = 512,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         WREQ_VALID,
    output logic [NUM_REQ-1:0]         WREQ_READY,
    input  logic [NUM_REQ*AW-1:0]      WREQ_ADDR,
    input  logic [NUM_REQ*WIDTH-1:0]   WREQ_DATA,
    input  logic [NUM_REQ*WIDTH/8-1:0] WREQ_STRB,
    input  logic [NUM_REQ-1:0]         RREQ_VALID,
    output logic [NUM_REQ-1:0]         RREQ_READY,
    input  logic [NUM_REQ*AW-1:0]      RREQ_ADDR,
    output logic [NUM_REQ-1:0]         RRSP_VALID,
    output logic [WIDTH-1:0]           RRSP_DATA,
    output logic                       RAM_WEN,
    output logic [AW-1:0]              RAM_WADDR,
    output logic [WIDTH-1:0]           RAM_WDATA,
    output logic [WIDTH/8-1:0]         RAM_WSTRB,
    output logic                       RAM_REN,
    output logic [AW-1:0]              RAM_RADDR,
    input  logic                       RAM_RVALID,
    input  logic [WIDTH-1:0]           RAM_RDATA
);

    localparam int unsigned SW = WIDTH / 8;

    logic [NUM_REQ-1:0] w_wgrant;
    logic [NUM_REQ-1:0] w_rgrant;
    logic [NUM_REQ-1:0] w_wacc;
    logic [NUM_REQ-1:0] w_racc;
    logic [IDX_W-1:0]   w_widx;
    logic [IDX_W-1:0]   w_ridx;
    rsp_tag_t           r_t1;
    rsp_tag_t           r_t2;
    logic [WIDTH-1:0]   r_rdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_warb (
        .CLK    (CLK),
        .RST    (RST),
        .VALID  (WREQ_VALID),
        .ACCEPT (|w_wacc),
        .GRANT  (w_wgrant)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rarb (
        .CLK    (CLK),
        .RST    (RST),
        .VALID  (RREQ_VALID),
        .ACCEPT (|w_racc),
        .GRANT  (w_rgrant)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM
    always_comb begin
        WREQ_READY = RST ? '0 : w_wgrant;
        RREQ_READY = RST ? '0 : w_rgrant;
        w_wacc     = WREQ_VALID & WREQ_READY;
        w_racc     = RREQ_VALID & RREQ_READY;
        w_widx     = onehot_to_idx(MAX_REQ'(w_wacc));
        w_ridx     = onehot_to_idx(MAX_REQ'(w_racc));
    end

    // Route the accepted requester's slices to the RAM ports
    always_comb begin
        RAM_WEN   = |w_wacc;
        RAM_WADDR = WREQ_ADDR[32'(w_widx)*AW +: AW];
        RAM_WDATA = WREQ_DATA[32'(w_widx)*WIDTH +: WIDTH];
        RAM_WSTRB = WREQ_STRB[32'(w_widx)*SW +: SW];
        RAM_REN   = |w_racc;
        RAM_RADDR = RREQ_ADDR[32'(w_ridx)*AW +: AW];
    end

    // Tag pipeline: t1 lines up with RAM_RVALID, t2 holds the issued response
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_t1    <= '0;
            r_t2    <= '0;
            r_rdata <= '0;
        end else begin
            r_t1 <= '{valid: RAM_REN, idx: w_ridx};
            if (RAM_RVALID && r_t1.valid) begin
                r_t2    <= r_t1;
                r_rdata <= RAM_RDATA;
            end else begin
                r_t2.valid <= 1'b0;
            end
        end
    end

    assign RRSP_VALID = r_t2.valid ? NUM_REQ'(idx_to_onehot(r_t2.idx)) : '0;
    assign RRSP_DATA  = r_rdata;

endmodule
